// File: rtl/direct_line_buf_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// direct_line_buf_ctrl_pkg : shared widths, line-buffer geometry, sideband type
// Rev 1.0
// ============================================================================
package direct_line_buf_ctrl_pkg;

    localparam int NUM_BANKS     = 64;
    localparam int LB_ROWS       = NUM_BANKS / 2;
    localparam int SRAM_AW       = 10;
    localparam int SRAM_DW       = 16;

    localparam int DATA_DEPTH_BW = 16;
    localparam int DATA_RGB_BW   = 8;
    localparam int H_SIZE_BW     = 10;
    localparam int V_SIZE_BW     = 9;
    localparam int CLOUD_BW      = 42;

    localparam int SLOT_BW       = $clog2(LB_ROWS);
    localparam int ROW_SBW       = V_SIZE_BW + 2;

    typedef logic [SLOT_BW-1:0] slot_t;

    typedef struct packed {
        logic [H_SIZE_BW-1:0]     idx0_x;
        logic [V_SIZE_BW-1:0]     idx0_y;
        logic [H_SIZE_BW-1:0]     idx1_x;
        logic [V_SIZE_BW-1:0]     idx1_y;
        logic [DATA_DEPTH_BW-1:0] depth0;
    } corr_sb_t;

endpackage
`default_nettype wire

// File: rtl/direct_line_buf_ctrl_if.sv
`default_nettype none
// ============================================================================
// direct_line_buf_ctrl_if : line-buffer SRAM bank bus (port A write, port B read)
// Rev 1.0
// ============================================================================
interface direct_line_buf_ctrl_if;
    import direct_line_buf_ctrl_pkg::*;

    logic [NUM_BANKS-1:0][SRAM_DW-1:0] QA;
    logic [NUM_BANKS-1:0][SRAM_DW-1:0] QB;
    logic [NUM_BANKS-1:0]              WENA;
    logic [NUM_BANKS-1:0]              WENB;
    logic [NUM_BANKS-1:0][SRAM_DW-1:0] DA;
    logic [NUM_BANKS-1:0][SRAM_DW-1:0] DB;
    logic [NUM_BANKS-1:0][SRAM_AW-1:0] AA;
    logic [NUM_BANKS-1:0][SRAM_AW-1:0] AB;

    modport master (
        input  QA, QB,
        output WENA, WENB, DA, DB, AA, AB
    );

    modport slave (
        output QA, QB,
        input  WENA, WENB, DA, DB, AA, AB
    );

endinterface
`default_nettype wire

// File: rtl/direct_line_buf_ctrl_read_pipe.sv
`default_nettype none
// ============================================================================
// lb_read_pipe : two-stage sideband delay and SRAM port-B output select
// Rev 1.0
// ============================================================================
module lb_read_pipe
    import direct_line_buf_ctrl_pkg::*;
(
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              i_frame_start,
    input  logic                              i_frame_end,
    input  logic                              i_hit_valid,
    input  corr_sb_t                          i_sb,
    input  slot_t                             i_slot,
    input  logic [NUM_BANKS-1:0][SRAM_DW-1:0] i_qb,
    output logic                              o_frame_start,
    output logic                              o_frame_end,
    output logic                              o_valid,
    output corr_sb_t                          o_sb,
    output logic [DATA_DEPTH_BW-1:0]          o_depth1,
    output logic [DATA_RGB_BW-1:0]            o_data1
);

    logic     r_s1_valid;
    logic     r_s1_fs;
    logic     r_s1_fe;
    corr_sb_t r_s1_sb;
    slot_t    r_s1_slot;

    logic [SRAM_DW-1:0] w_q_depth;
    logic [SRAM_DW-1:0] w_q_pix;

    // SRAM data for the stage-1 address is available one cycle after it was issued
    assign w_q_depth = i_qb[{r_s1_slot, 1'b0}];
    assign w_q_pix   = i_qb[{r_s1_slot, 1'b1}];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid    <= 1'b0;
            r_s1_fs       <= 1'b0;
            r_s1_fe       <= 1'b0;
            r_s1_sb       <= '0;
            r_s1_slot     <= '0;
            o_valid       <= 1'b0;
            o_frame_start <= 1'b0;
            o_frame_end   <= 1'b0;
            o_sb          <= '0;
            o_depth1      <= '0;
            o_data1       <= '0;
        end else begin
            r_s1_valid    <= i_hit_valid;
            r_s1_fs       <= i_frame_start;
            r_s1_fe       <= i_frame_end;
            r_s1_sb       <= i_sb;
            r_s1_slot     <= i_slot;
            o_valid       <= r_s1_valid;
            o_frame_start <= r_s1_fs;
            o_frame_end   <= r_s1_fe;
            o_sb          <= r_s1_sb;
            o_depth1      <= DATA_DEPTH_BW'(w_q_depth);
            o_data1       <= w_q_pix[DATA_RGB_BW-1:0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/direct_line_buf_ctrl.sv
`default_nettype none
// ============================================================================
// direct_line_buf_ctrl : 32-row rolling frame-1 line buffer, fixed 2-cycle lookup
// Rev 1.0
// ============================================================================
module direct_line_buf_ctrl
    import direct_line_buf_ctrl_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_frame_start,
    input  logic                        i_frame_end,
    input  logic                        i_valid0,
    input  logic [DATA_DEPTH_BW-1:0]    i_depth0,
    input  logic signed [CLOUD_BW-1:0]  i_trans_z1,
    input  logic [H_SIZE_BW-1:0]        i_idx0_x,
    input  logic [V_SIZE_BW-1:0]        i_idx0_y,
    input  logic [H_SIZE_BW-1:0]        i_idx1_x,
    input  logic [V_SIZE_BW-1:0]        i_idx1_y,
    input  logic                        i_valid1,
    input  logic [DATA_RGB_BW-1:0]      i_data1,
    input  logic [DATA_DEPTH_BW-1:0]    i_depth1,
    input  logic [H_SIZE_BW-1:0]        r_hsize,
    input  logic [V_SIZE_BW-1:0]        r_vsize,
    direct_line_buf_ctrl_if.master      lb_sram,
    output logic                        o_frame_start,
    output logic                        o_frame_end,
    output logic                        o_valid,
    output logic [H_SIZE_BW-1:0]        o_idx0_x,
    output logic [V_SIZE_BW-1:0]        o_idx0_y,
    output logic [H_SIZE_BW-1:0]        o_idx1_x,
    output logic [V_SIZE_BW-1:0]        o_idx1_y,
    output logic [DATA_DEPTH_BW-1:0]    o_depth0,
    output logic [DATA_DEPTH_BW-1:0]    o_depth1,
    output logic [DATA_RGB_BW-1:0]      o_data1
);

    localparam logic [H_SIZE_BW-1:0]      c_H_ONE     = H_SIZE_BW'(1);
    localparam logic [V_SIZE_BW-1:0]      c_V_ONE     = V_SIZE_BW'(1);
    localparam logic signed [ROW_SBW-1:0] c_S_ONE     = ROW_SBW'(1);
    localparam logic signed [ROW_SBW-1:0] c_OPEN_SPAN = ROW_SBW'(LB_ROWS - 1);
    localparam logic signed [ROW_SBW-1:0] c_FULL_SPAN = ROW_SBW'(LB_ROWS);

    // ---------------- write side (port A) ----------------
    logic [H_SIZE_BW-1:0] r_wx;
    logic [V_SIZE_BW-1:0] r_wrow;
    logic                 w_wr_en;
    slot_t                w_wr_slot;

    logic [NUM_BANKS-1:0]              w_wena;
    logic [NUM_BANKS-1:0][SRAM_AW-1:0] w_aa;
    logic [NUM_BANKS-1:0][SRAM_DW-1:0] w_da;

    assign w_wr_en   = i_valid1 && (r_wrow < r_vsize);
    assign w_wr_slot = r_wrow[SLOT_BW-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wx   <= '0;
            r_wrow <= '0;
        end else if (i_frame_end) begin
            r_wx   <= '0;
            r_wrow <= '0;
        end else if (w_wr_en) begin
            if (r_wx == (r_hsize - c_H_ONE)) begin
                r_wx   <= '0;
                r_wrow <= r_wrow + c_V_ONE;
            end else begin
                r_wx   <= r_wx + c_H_ONE;
            end
        end
    end

    always_comb begin
        w_wena = '1;
        w_aa   = '0;
        w_da   = '0;
        if (w_wr_en) begin
            w_wena[{w_wr_slot, 1'b0}] = 1'b0;
            w_wena[{w_wr_slot, 1'b1}] = 1'b0;
            w_aa[{w_wr_slot, 1'b0}]   = SRAM_AW'(r_wx);
            w_aa[{w_wr_slot, 1'b1}]   = SRAM_AW'(r_wx);
            w_da[{w_wr_slot, 1'b0}]   = SRAM_DW'(i_depth1);
            w_da[{w_wr_slot, 1'b1}]   = SRAM_DW'(i_data1);
        end
    end

    assign lb_sram.WENA = w_wena;
    assign lb_sram.AA   = w_aa;
    assign lb_sram.DA   = w_da;

    // ---------------- read side (port B) ----------------
    logic [NUM_BANKS-1:0][SRAM_AW-1:0] r_ab;
    logic [NUM_BANKS-1:0][SRAM_AW-1:0] w_ab;
    slot_t                             w_rd_slot;

    assign w_rd_slot = i_idx1_y[SLOT_BW-1:0];

    // Untouched banks keep their last address so idle SRAM ports see no toggling
    always_comb begin
        w_ab = r_ab;
        if (i_valid0) begin
            w_ab[{w_rd_slot, 1'b0}] = SRAM_AW'(i_idx1_x);
            w_ab[{w_rd_slot, 1'b1}] = SRAM_AW'(i_idx1_x);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ab <= '0;
        end else begin
            r_ab <= w_ab;
        end
    end

    assign lb_sram.AB   = w_ab;
    assign lb_sram.WENB = '1;
    assign lb_sram.DB   = '0;

    logic w_unused_qa;
    assign w_unused_qa = ^lb_sram.QA;

    // ---------------- window check ----------------
    // The row under construction is never a hit; once the frame is complete all 32 slots are
    logic signed [ROW_SBW-1:0] w_row_s;
    logic signed [ROW_SBW-1:0] w_y_s;
    logic signed [ROW_SBW-1:0] w_lo;
    logic signed [ROW_SBW-1:0] w_hi;
    logic                      w_z_pos;
    logic                      w_hit;

    assign w_row_s = $signed({2'b00, r_wrow});
    assign w_y_s   = $signed({2'b00, i_idx1_y});
    assign w_hi    = w_row_s - c_S_ONE;
    assign w_lo    = w_row_s - ((r_wrow == r_vsize) ? c_FULL_SPAN : c_OPEN_SPAN);
    assign w_z_pos = !i_trans_z1[CLOUD_BW-1] && (|i_trans_z1);
    assign w_hit   = i_valid0 && w_z_pos && (w_y_s >= w_lo) && (w_y_s <= w_hi);

    corr_sb_t w_in_sb;
    corr_sb_t w_out_sb;

    assign w_in_sb.idx0_x = i_idx0_x;
    assign w_in_sb.idx0_y = i_idx0_y;
    assign w_in_sb.idx1_x = i_idx1_x;
    assign w_in_sb.idx1_y = i_idx1_y;
    assign w_in_sb.depth0 = i_depth0;

    lb_read_pipe u_read_pipe (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_frame_start (i_frame_start),
        .i_frame_end   (i_frame_end),
        .i_hit_valid   (w_hit),
        .i_sb          (w_in_sb),
        .i_slot        (w_rd_slot),
        .i_qb          (lb_sram.QB),
        .o_frame_start (o_frame_start),
        .o_frame_end   (o_frame_end),
        .o_valid       (o_valid),
        .o_sb          (w_out_sb),
        .o_depth1      (o_depth1),
        .o_data1       (o_data1)
    );

    assign o_idx0_x = w_out_sb.idx0_x;
    assign o_idx0_y = w_out_sb.idx0_y;
    assign o_idx1_x = w_out_sb.idx1_x;
    assign o_idx1_y = w_out_sb.idx1_y;
    assign o_depth0 = w_out_sb.depth0;

endmodule
`default_nettype wire

// File: tb/tb_direct_line_buf_ctrl.sv
`default_nettype none
// ============================================================================
// tb_direct_line_buf_ctrl : directed bench with behavioural dual-port SRAM banks
// Rev 1.0
// ============================================================================
module tb_direct_line_buf_ctrl;
    import direct_line_buf_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic                       frame_start = 1'b0, frame_end = 1'b0;
    logic                       valid0 = 1'b0, valid1 = 1'b0;
    logic [DATA_DEPTH_BW-1:0]   depth0 = '0, depth1 = '0;
    logic signed [CLOUD_BW-1:0] trans_z1 = '0;
    logic [H_SIZE_BW-1:0]       idx0_x = '0, idx1_x = '0;
    logic [V_SIZE_BW-1:0]       idx0_y = '0, idx1_y = '0;
    logic [DATA_RGB_BW-1:0]     data1 = '0;
    logic [H_SIZE_BW-1:0]       hsize = 10'd640;
    logic [V_SIZE_BW-1:0]       vsize = 9'd480;

    logic                       o_fs, o_fe, o_valid;
    logic [H_SIZE_BW-1:0]       o_idx0_x, o_idx1_x;
    logic [V_SIZE_BW-1:0]       o_idx0_y, o_idx1_y;
    logic [DATA_DEPTH_BW-1:0]   o_depth0, o_depth1;
    logic [DATA_RGB_BW-1:0]     o_data1;

    direct_line_buf_ctrl_if sif ();

    direct_line_buf_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_frame_start (frame_start),
        .i_frame_end   (frame_end),
        .i_valid0      (valid0),
        .i_depth0      (depth0),
        .i_trans_z1    (trans_z1),
        .i_idx0_x      (idx0_x),
        .i_idx0_y      (idx0_y),
        .i_idx1_x      (idx1_x),
        .i_idx1_y      (idx1_y),
        .i_valid1      (valid1),
        .i_data1       (data1),
        .i_depth1      (depth1),
        .r_hsize       (hsize),
        .r_vsize       (vsize),
        .lb_sram       (sif.master),
        .o_frame_start (o_fs),
        .o_frame_end   (o_fe),
        .o_valid       (o_valid),
        .o_idx0_x      (o_idx0_x),
        .o_idx0_y      (o_idx0_y),
        .o_idx1_x      (o_idx1_x),
        .o_idx1_y      (o_idx1_y),
        .o_depth0      (o_depth0),
        .o_depth1      (o_depth1),
        .o_data1       (o_data1)
    );

    // Behavioural synchronous dual-port 1024x16 banks
    logic [SRAM_DW-1:0] mem [NUM_BANKS][1024];
    always @(posedge clk) begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (!sif.WENA[b]) mem[b][sif.AA[b]] <= sif.DA[b];
            if (!sif.WENB[b]) mem[b][sif.AB[b]] <= sif.DB[b];
            sif.QA[b] <= mem[b][sif.AA[b]];
            sif.QB[b] <= mem[b][sif.AB[b]];
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic stream_rows(input int y0, input int n, input int h);
        logic [63:0] mask;
        for (int y = y0; y < y0 + n; y++) begin
            for (int x = 0; x < h; x++) begin
                @(negedge clk);
                valid1 = 1'b1;
                depth1 = 16'(y * h + x);
                data1  = 8'(x);
                if (y == y0 && x == 1) begin
                    #1;
                    mask = '1;
                    mask[2 * (y % 32)]     = 1'b0;
                    mask[2 * (y % 32) + 1] = 1'b0;
                    check("wr_wena", 64'(sif.WENA), mask);
                    check("wr_aa", 64'(sif.AA[2 * (y % 32) + 1]), 64'(x));
                    check("wr_da_depth", 64'(sif.DA[2 * (y % 32)]), 64'(y * h + x) & 64'hFFFF);
                    check("wr_da_pix", 64'(sif.DA[2 * (y % 32) + 1]), 64'(x));
                end
            end
        end
        @(negedge clk);
        valid1 = 1'b0;
    endtask

    task automatic query(input string tag, input int x, input int y, input longint z,
                         input bit exp_v, input int exp_d, input int exp_p);
        @(negedge clk);
        valid0   = 1'b1;
        idx1_x   = 10'(x);
        idx1_y   = 9'(y);
        idx0_x   = 10'(x ^ 5);
        idx0_y   = 9'(y + 3);
        depth0   = 16'(x * 7 + y);
        trans_z1 = 42'(z);
        @(negedge clk);
        valid0 = 1'b0;
        @(negedge clk);
        check({tag, ".valid"}, 64'(o_valid), 64'(exp_v));
        if (exp_v) begin
            check({tag, ".depth1"}, 64'(o_depth1), 64'(exp_d));
            check({tag, ".data1"}, 64'(o_data1), 64'(exp_p));
        end
        check({tag, ".idx1_x"}, 64'(o_idx1_x), 64'(x));
        check({tag, ".idx1_y"}, 64'(o_idx1_y), 64'(y));
        check({tag, ".idx0_y"}, 64'(o_idx0_y), 64'(y + 3));
        check({tag, ".depth0"}, 64'(o_depth0), 64'(x * 7 + y));
    endtask

    task automatic pulse_check(input bit is_end);
        @(negedge clk);
        if (is_end) frame_end = 1'b1;
        else        frame_start = 1'b1;
        @(negedge clk);
        frame_end   = 1'b0;
        frame_start = 1'b0;
        check(is_end ? "fe_d1" : "fs_d1", 64'(is_end ? o_fe : o_fs), 64'd0);
        @(negedge clk);
        check(is_end ? "fe_d2" : "fs_d2", 64'(is_end ? o_fe : o_fs), 64'd1);
        @(negedge clk);
        check(is_end ? "fe_d3" : "fs_d3", 64'(is_end ? o_fe : o_fs), 64'd0);
    endtask

    initial begin
        // reset state
        repeat (3) @(negedge clk);
        check("rst.valid", 64'(o_valid), 64'd0);
        check("rst.depth1", 64'(o_depth1), 64'd0);
        check("rst.fs", 64'(o_fs), 64'd0);
        check("rst.wena", 64'(sif.WENA), {64{1'b1}});
        check("rst.wenb", 64'(sif.WENB), {64{1'b1}});
        check("rst.aa", 64'(|sif.AA), 64'd0);
        check("rst.ab", 64'(|sif.AB), 64'd0);
        check("rst.db", 64'(|sif.DB), 64'd0);
        rst_n = 1'b1;

        // 640 x 40 ramp: window is rows 9..39
        stream_rows(0, 40, 640);
        query("a_mid",   100, 20,  1, 1'b1, 12900, 100);
        query("a_lo",      5,  9,  7, 1'b1,  5765,   5);
        query("a_hi",    639, 39,  1, 1'b1, 25599, 127);
        query("a_old",     3,  8,  1, 1'b0,     0,   0);
        query("a_new",     3, 40,  1, 1'b0,     0,   0);
        query("a_zneg",  100, 20, -5, 1'b0,     0,   0);
        query("a_zzero", 100, 20,  0, 1'b0,     0,   0);
        pulse_check(1'b0);
        pulse_check(1'b1);
        query("a_clr",   100, 20,  1, 1'b0,     0,   0);

        // 64-wide frame, 33 rows: slot 0 now holds row 32
        hsize = 10'd64;
        stream_rows(0, 33, 64);
        query("b_reuse",  10, 32,  1, 1'b1,  2058,  10);
        query("b_lo",     10,  2,  1, 1'b1,   138,  10);
        query("b_old",    10,  1,  1, 1'b0,     0,   0);

        // finish the frame, then push pixels that must be ignored
        stream_rows(33, 447, 64);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            valid1 = 1'b1;
            depth1 = 16'hDEAD;
            data1  = 8'hEE;
        end
        @(negedge clk);
        valid1 = 1'b0;
        query("c_last",   63, 479, 1, 1'b1, 30719,  63);
        query("c_lo",      0, 448, 1, 1'b1, 28672,   0);
        query("c_old",     5, 447, 1, 1'b0,     0,   0);
        pulse_check(1'b1);
        query("c_clr",    63, 479, 1, 1'b0,     0,   0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
